// File: rtl/clken_sched.sv
// CPU clock-enable scheduler: divides cpu_clk into CPU/VIA strobes and adds run/halt/step control.
// Optional breakpoint comparator is built when DIGIAC_BREAKPOINT_EN is defined.
module clken_sched #(
   parameter int DIV     = 16,
   parameter int VIA_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        step,
   input  logic        sync,
   input  logic [15:0] ab,
   input  logic [15:0] bp_addr,
   input  logic        bp_en,
   output logic        cpu_clken,
   output logic        cpu_clken1,
   output logic        via_clken,
   output logic        phi2,
   output logic        halted,
   output logic        bp_hit
);
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST    = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_PHI_CLR = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] VIA_MASK    = CW'(VIA_DIV - 1);

   typedef enum logic [1:0] {S_RUN, S_HALTED, S_STEP} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [1:0]    vld_pipe;
   logic          step_pend, slot, issue, halt_cond, bp_match;

   assign slot = (cnt == CNT_LAST);

`ifdef DIGIAC_BREAKPOINT_EN
   assign bp_match = (state == S_RUN) && slot && bp_en && sync && (ab == bp_addr);
`else
   logic unused_bp;
   assign unused_bp = ^{bp_addr, bp_en};
   assign bp_match  = 1'b0;
`endif

   assign halt_cond = !run || bp_match;

   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      case (state)
         S_RUN: begin
            if (slot && sync && halt_cond) state_nx = S_HALTED;
            else                           issue    = 1'b1;
         end
         S_HALTED: begin
            // a step pulse landing on the slot itself still counts
            if (slot && run) begin
               issue    = 1'b1;
               state_nx = S_RUN;
            end else if (slot && (step_pend || step)) begin
               issue    = 1'b1;
               state_nx = S_STEP;
            end
         end
         S_STEP: begin
            if (slot && sync) state_nx = run ? S_RUN : S_HALTED;
            else              issue    = 1'b1;
         end
         default: state_nx = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else       cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_RUN;
         step_pend <= 1'b0;
         vld_pipe  <= '0;
         via_clken <= 1'b0;
         phi2      <= 1'b0;
         halted    <= 1'b0;
      end else begin
         state    <= state_nx;
         vld_pipe <= {vld_pipe[0], slot && issue};
         if (state == S_HALTED && state_nx != S_HALTED) step_pend <= 1'b0;
         else if (state == S_HALTED && step)            step_pend <= 1'b1;
         via_clken <= ((cnt & VIA_MASK) == VIA_MASK);
         // phi2 tracks the first half of an enabled CPU cycle only
         if (slot && issue)             phi2 <= 1'b1;
         else if (cnt == CNT_PHI_CLR)   phi2 <= 1'b0;
         halted <= (state_nx == S_HALTED);
      end
   end

   assign cpu_clken  = vld_pipe[0];
   assign cpu_clken1 = vld_pipe[1];

`ifdef DIGIAC_BREAKPOINT_EN
   always_ff @(posedge clk) begin
      if (reset)                                           bp_hit <= 1'b0;
      else if (bp_match)                                   bp_hit <= 1'b1;
      else if (state == S_HALTED && state_nx != S_HALTED)  bp_hit <= 1'b0;
   end
`else
   assign bp_hit = 1'b0;
`endif

endmodule

// File: tb/tb_clken_sched.sv
// Directed bench for clken_sched: cycle-level model plus literal checks of the main scenarios.
module tb_clken_sched;
   localparam int DIV = 16, VIA = 4;
   localparam int M_RUN = 0, M_HLT = 1, M_STP = 2;

   logic clk = 1'b0, reset = 1'b1, run = 1'b1, step = 1'b0, bp_en = 1'b0, sync;
   logic [15:0] ab, bp_addr = 16'h0000;
   logic cpu_clken, cpu_clken1, via_clken, phi2, halted, bp_hit;

   clken_sched #(.DIV(DIV), .VIA_DIV(VIA)) dut (
      .clk(clk), .reset(reset), .run(run), .step(step), .sync(sync), .ab(ab),
      .bp_addr(bp_addr), .bp_en(bp_en), .cpu_clken(cpu_clken), .cpu_clken1(cpu_clken1),
      .via_clken(via_clken), .phi2(phi2), .halted(halted), .bp_hit(bp_hit)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   // CPU model: fixed 3-cycle instructions, optionally a JMP-to-self loop
   logic [15:0] c_pc, c_start;
   int          c_ph;
   bit          c_loop;

   // spec-level model state
   int   m_t, m_mode;
   bit   m_pend, m_bphit, mvalid = 1'b0;
   logic e_clken = 0, e_clken1 = 0, e_via = 0, e_phi2 = 0, e_halted = 0;

   bit [63:0] lg_ck, lg_via, lg_phi;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, m_t);
   endtask

   task automatic cpu_drive();
      sync = (c_ph == 0);
      ab   = c_pc + 16'(c_ph);
   endtask

   task automatic cyc();
      logic r_reset, r_run, r_step, r_sync, r_adv, r_bpen, bpm, slot, issue;
      logic [15:0] r_ab, r_bpa;
      int nmode;
      r_reset = reset; r_run = run; r_step = step; r_sync = sync; r_ab = ab;
      r_bpen = bp_en; r_bpa = bp_addr; r_adv = cpu_clken;
      @(posedge clk); #1;
      if (r_reset) begin
         m_t = 0; m_mode = M_RUN; m_pend = 0; m_bphit = 0; mvalid = 1;
         {e_clken, e_clken1, e_via, e_phi2, e_halted} = '0;
         c_pc = c_start; c_ph = 0;
      end else begin
         slot  = ((m_t % DIV) == DIV - 1);
         issue = 1'b1;
         nmode = m_mode;
`ifdef DIGIAC_BREAKPOINT_EN
         bpm = r_bpen && r_sync && (r_ab == r_bpa);
`else
         bpm = 1'b0;
`endif
         if (slot) begin
            if (m_mode == M_RUN) begin
               if (r_sync && (!r_run || bpm)) begin
                  issue = 0; nmode = M_HLT;
                  if (bpm) m_bphit = 1;
               end
            end else if (m_mode == M_HLT) begin
               if (r_run)                 nmode = M_RUN;
               else if (m_pend || r_step) nmode = M_STP;
               else                       issue = 0;
            end else if (r_sync) begin
               issue = 0; nmode = r_run ? M_RUN : M_HLT;
            end
         end
         if (m_mode == M_HLT) begin
            if (nmode != M_HLT) begin m_pend = 0; m_bphit = 0; end
            else if (r_step) m_pend = 1;
         end
         e_clken1 = e_clken;
         e_clken  = slot && issue;
         e_via    = (((m_t + 1) % VIA) == 0);
         if (e_clken) e_phi2 = 1;
         else if (((m_t + 1) % DIV) == DIV / 2) e_phi2 = 0;
         e_halted = (nmode == M_HLT);
         m_mode   = nmode;
         m_t++;
         if (r_adv) begin
            c_ph++;
            if (c_ph == 3) begin c_ph = 0; if (!c_loop) c_pc = c_pc + 16'd3; end
         end
      end
      cpu_drive();
   endtask

   always @(negedge clk) begin
      if (mvalid) begin
         chk("cpu_clken", cpu_clken, e_clken);
         chk("cpu_clken1", cpu_clken1, e_clken1);
         chk("via_clken", via_clken, e_via);
         chk("phi2", phi2, e_phi2);
         chk("halted", halted, e_halted);
         chk("bp_hit", bp_hit, m_bphit);
      end
   end

   task automatic wait_halted(input logic val, input int bound, input string nm, output int nck);
      nck = 0;
      for (int i = 0; i < bound && halted !== val; i++) begin
         cyc();
         if (cpu_clken) nck++;
      end
      n_chk++;
      if (halted === val) n_pass++;
      else $display("FAIL %s: halted=%b after %0d cycles, want %b", nm, halted, bound, val);
   endtask

   task automatic run_log(input int n);
      lg_ck = '0; lg_via = '0; lg_phi = '0;
      for (int i = 0; i < n; i++) begin
         lg_ck[i] = cpu_clken; lg_via[i] = via_clken; lg_phi[i] = phi2;
         cyc();
      end
   endtask

   task automatic do_reset();
      reset = 1; cyc(); cyc(); reset = 0;
   endtask

   initial begin
      int n, n1, n2, t0, hl, first;
      c_start = 16'hC010; c_pc = c_start; c_ph = 0; c_loop = 1;
      cpu_drive();

      // free run after reset
      do_reset();
      chk("reset_clken", cpu_clken, 0);
      chk("reset_halted", halted, 0);
      run_log(50);
      chk("clken_16", lg_ck[16], 1); chk("clken_32", lg_ck[32], 1); chk("clken_48", lg_ck[48], 1);
      chk("clken_count", $countones(lg_ck[49:0]), 3);
      chk("via_4", lg_via[4], 1); chk("via_8", lg_via[8], 1); chk("via_12", lg_via[12], 1);
      chk("via_count_0_15", $countones(lg_via[15:0]), 3);
      chk("phi2_15", lg_phi[15], 0);
      chk("phi2_16_23", lg_phi[23:16], 8'hFF);
      chk("phi2_24", lg_phi[24], 0);

      // halt request lands on an opcode fetch
      t0 = m_t; run = 0;
      wait_halted(1, 100, "halt_on_run_low", n);
      chk("halt_clken_suppressed", cpu_clken, 0);
      chk("halt_sync", sync, 1);
      chk("halt_ab", ab, 16'hC010);
      chk("halt_after_slot", m_t % DIV, 0);
      chk("halt_latency", (m_t - t0) <= 5 * DIV, 1);
      n = 0;
      for (int i = 0; i < 40; i++) begin cyc(); if (cpu_clken) n++; end
      chk("halted_no_enables", n, 0);
      chk("halted_ab_hold", ab, 16'hC010);

      // two step pulses close together give one instruction
      step = 1; cyc(); step = 0; cyc(); step = 1; cyc(); step = 0;
      wait_halted(0, 40, "step_leave", n1);
      wait_halted(1, 100, "step_done", n2);
      chk("step_enables", n1 + n2, 3);
      chk("step_ab", ab, 16'hC010);
      chk("step_sync", sync, 1);

      // run and step together: run wins, no stale step afterwards
      run = 1; step = 1; cyc(); step = 0;
      wait_halted(0, 40, "resume", n);
      n = 0; hl = 0;
      for (int i = 0; i < 48; i++) begin cyc(); if (cpu_clken) n++; if (halted) hl++; end
      chk("resume_enables", n, 3);
      chk("resume_not_halted", hl, 0);
      run = 0;
      wait_halted(1, 100, "rehalt", n);
      n = 0;
      for (int i = 0; i < 48; i++) begin cyc(); if (cpu_clken) n++; end
      chk("no_stale_step", n, 0);

      // reset in the middle of a step
      step = 1; cyc(); step = 0;
      wait_halted(0, 40, "step2_leave", n);
      cyc(); cyc(); cyc();
      run = 1; reset = 1; cyc(); reset = 0;
      chk("rst_clken", cpu_clken, 0); chk("rst_clken1", cpu_clken1, 0);
      chk("rst_via", via_clken, 0);   chk("rst_phi2", phi2, 0);
      chk("rst_halted", halted, 0);   chk("rst_bp_hit", bp_hit, 0);
      run_log(50);
      first = -1;
      for (int i = 49; i >= 0; i--) if (lg_ck[i]) first = i;
      chk("rst_first_enable", first, 16);
      chk("rst_enable_count", $countones(lg_ck[49:0]), 3);

      // breakpoint at C123 on straight-line code
      c_start = 16'hC11D; c_loop = 0; bp_addr = 16'hC123; bp_en = 1; run = 1;
      do_reset();
`ifdef DIGIAC_BREAKPOINT_EN
      wait_halted(1, 200, "bp_halt", n);
      run = 0;
      chk("bp_hit_set", bp_hit, 1);
      chk("bp_ab", ab, 16'hC123);
      chk("bp_sync", sync, 1);
      step = 1; cyc(); step = 0;
      wait_halted(0, 40, "bp_step_leave", n1);
      chk("bp_hit_cleared", bp_hit, 0);
      wait_halted(1, 100, "bp_step_done", n2);
      chk("bp_step_enables", n1 + n2, 3);
      chk("bp_step_ab", ab, 16'hC126);
      chk("bp_hit_after_step", bp_hit, 0);
`else
      hl = 0;
      for (int i = 0; i < 160; i++) begin cyc(); if (halted) hl++; end
      chk("no_bp_halt", hl, 0);
      chk("bp_passed", ab > 16'hC123, 1);
      chk("bp_hit_tied", bp_hit, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
